cache_replacement_process: RTL and testbench



---
 rtl/cache_replacement_process.sv | 175 +++++++++++++++++
 tb/tb_cache_replacement_process.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_replacement_process.sv
// -----------------------------------------------------------------------------
// cache_replacement_process
//
// Keeps way-replacement state for every set of a set-associative cache and
// presents the victim way for the addressed set. The policy is fixed when the
// block is elaborated:
//   REP_POLICY = 0 : true LRU (per-way rank, 0 = least recent)
//   REP_POLICY = 1 : PLRU-MRU (one "recently used" bit per way)
//   REP_POLICY = 2 : PLRU binary tree (heap-ordered node bits, root = node 1)
//   any other value behaves as 0.
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   reset      : synchronous, active-low; clears every set, priority over writes
//   write_en   : update strobe for the set at line_addr
//   way_hit    : one-hot way just hit/filled (lowest set bit wins, 0 = no-op)
//   line_addr  : set index (ignored when LINE_OFF_W = 0)
//   way_select : victim way for line_addr, combinational from stored state
// -----------------------------------------------------------------------------
module cache_replacement_process #(
    parameter int N_WAYS     = 8,
    parameter int LINE_OFF_W = 0,
    parameter int REP_POLICY = 0
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic                                     write_en,
    input  logic [N_WAYS-1:0]                        way_hit,
    input  logic [((LINE_OFF_W > 0) ? LINE_OFF_W : 1)-1:0] line_addr,
    output logic [$clog2(N_WAYS)-1:0]                way_select
);

    localparam int WW     = $clog2(N_WAYS);
    localparam int N_SETS = 1 << LINE_OFF_W;
    localparam int AW     = (LINE_OFF_W > 0) ? LINE_OFF_W : 1;

    logic [AW-1:0] set_idx;
    logic [WW-1:0] hit_idx;
    logic          do_update;

    generate
        if (LINE_OFF_W == 0) begin : g_single_set
            // Only one set exists; the address port is kept for a uniform interface.
            logic unused_line_addr;
            assign unused_line_addr = ^line_addr;
            assign set_idx          = '0;
        end else begin : g_multi_set
            assign set_idx = line_addr;
        end
    endgenerate

    // Lowest set bit of way_hit; scanning downward lets the lowest index win.
    always_comb begin
        hit_idx = '0;
        for (int i = N_WAYS - 1; i >= 0; i--) begin
            if (way_hit[i]) hit_idx = WW'(i);
        end
    end

    assign do_update = write_en & (|way_hit);

    generate
        if (REP_POLICY == 1) begin : g_plru_mru
            logic [N_WAYS-1:0] mru_q [N_SETS];
            logic [N_WAYS-1:0] mru_cur;
            logic [N_WAYS-1:0] mru_hit_oh;
            logic [N_WAYS-1:0] mru_set;
            logic [N_WAYS-1:0] mru_nxt;
            logic [WW-1:0]     mru_sel;

            always_comb begin
                mru_cur             = mru_q[set_idx];
                mru_hit_oh          = '0;
                mru_hit_oh[hit_idx] = 1'b1;
                mru_set             = mru_cur | mru_hit_oh;
                // Saturation: keep only the way just touched so a victim always exists.
                mru_nxt             = (&mru_set) ? mru_hit_oh : mru_set;
                mru_sel             = '0;
                for (int i = N_WAYS - 1; i >= 0; i--) begin
                    if (!mru_cur[i]) mru_sel = WW'(i);
                end
            end

            always_ff @(posedge clk) begin
                if (!reset) begin
                    for (int s = 0; s < N_SETS; s++) begin
                        mru_q[s] <= '0;
                    end
                end else if (do_update) begin
                    mru_q[set_idx] <= mru_nxt;
                end
            end

            assign way_select = mru_sel;

        end else if (REP_POLICY == 2) begin : g_plru_tree
            // Node n lives at bit n; bit 0 would be unused, so the vector starts at 1.
            logic [N_WAYS-1:1] tree_q [N_SETS];
            logic [N_WAYS-1:1] tree_cur;
            logic [N_WAYS-1:1] tree_nxt;
            logic [WW-1:0]     tree_sel;
            int                up_node;
            int                dn_node;

            always_comb begin
                tree_cur = tree_q[set_idx];
                tree_nxt = tree_cur;
                // Walk from the hit leaf (heap index N_WAYS + h) up to the root. An odd
                // child is the higher subtree, so its parent must point low (0).
                up_node  = N_WAYS + int'(hit_idx);
                for (int l = 0; l < WW; l++) begin
                    tree_nxt[up_node >> 1] = ~up_node[0];
                    up_node                = up_node >> 1;
                end
                dn_node = 1;
                for (int l = 0; l < WW; l++) begin
                    dn_node = 2 * dn_node + (tree_cur[dn_node] ? 1 : 0);
                end
                tree_sel = WW'(dn_node - N_WAYS);
            end

            always_ff @(posedge clk) begin
                if (!reset) begin
                    for (int s = 0; s < N_SETS; s++) begin
                        tree_q[s] <= '0;
                    end
                end else if (do_update) begin
                    tree_q[set_idx] <= tree_nxt;
                end
            end

            assign way_select = tree_sel;

        end else begin : g_lru
            logic [WW-1:0] rank_q   [N_SETS][N_WAYS];
            logic [WW-1:0] rank_cur [N_WAYS];
            logic [WW-1:0] rank_nxt [N_WAYS];
            logic [WW-1:0] rank_h;
            logic [WW-1:0] lru_sel;

            always_comb begin
                for (int i = 0; i < N_WAYS; i++) begin
                    rank_cur[i] = rank_q[set_idx][i];
                end
                rank_h = rank_cur[hit_idx];
                // Ways more recent than h slide down one rank; h becomes most recent.
                for (int i = 0; i < N_WAYS; i++) begin
                    rank_nxt[i] = (rank_cur[i] > rank_h) ? (rank_cur[i] - WW'(1)) : rank_cur[i];
                end
                rank_nxt[hit_idx] = WW'(N_WAYS - 1);
                lru_sel = '0;
                for (int i = 0; i < N_WAYS; i++) begin
                    if (rank_cur[i] == '0) lru_sel = WW'(i);
                end
            end

            always_ff @(posedge clk) begin
                if (!reset) begin
                    for (int s = 0; s < N_SETS; s++) begin
                        for (int i = 0; i < N_WAYS; i++) begin
                            rank_q[s][i] <= WW'(i);
                        end
                    end
                end else if (do_update) begin
                    for (int i = 0; i < N_WAYS; i++) begin
                        rank_q[set_idx][i] <= rank_nxt[i];
                    end
                end
            end

            assign way_select = lru_sel;
        end
    endgenerate

endmodule

// File: tb/tb_cache_replacement_process.sv
// -----------------------------------------------------------------------------
// Bench for cache_replacement_process.
//   - three 4-way single-set instances (LRU, PLRU-MRU, PLRU-tree) driven from a
//     table of {reset, write, hit, expected victim} records
//   - one 4-way two-set LRU instance for the set isolation / reset sequences
//   - four 8-way four-set instances (policies 0..3) under random stimulus,
//     compared against a recency-queue / bit-vector / range-split model
// -----------------------------------------------------------------------------
module tb_cache_replacement_process;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    // ---------------- small single-set group ----------------
    logic       we_s  [3];
    logic [3:0] hit_s [3];
    logic [1:0] sel_s [3];
    logic       zero_addr;

    for (genvar p = 0; p < 3; p++) begin : g_small
        cache_replacement_process #(.N_WAYS(4), .LINE_OFF_W(0), .REP_POLICY(p)) u_dut (
            .clk       (clk),
            .reset     (reset),
            .write_en  (we_s[p]),
            .way_hit   (hit_s[p]),
            .line_addr (zero_addr),
            .way_select(sel_s[p])
        );
    end

    // ---------------- two-set LRU ----------------
    logic       we_m;
    logic [3:0] hit_m;
    logic       addr_m;
    logic [1:0] sel_m;

    cache_replacement_process #(.N_WAYS(4), .LINE_OFF_W(1), .REP_POLICY(0)) u_multi (
        .clk       (clk),
        .reset     (reset),
        .write_en  (we_m),
        .way_hit   (hit_m),
        .line_addr (addr_m),
        .way_select(sel_m)
    );

    // ---------------- random group: 8 ways, 4 sets ----------------
    logic       we_b;
    logic [7:0] hit_b;
    logic [1:0] addr_b;
    logic [2:0] sel_b [4];

    for (genvar p = 0; p < 4; p++) begin : g_big
        cache_replacement_process #(.N_WAYS(8), .LINE_OFF_W(2), .REP_POLICY(p)) u_dut (
            .clk       (clk),
            .reset     (reset),
            .write_en  (we_b),
            .way_hit   (hit_b),
            .line_addr (addr_b),
            .way_select(sel_b[p])
        );
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    // ---------------- reference model ----------------
    // LRU: queue of ways ordered least -> most recent.
    int lq [4][$];
    bit mb [4][8];
    bit tn [4][8];

    function automatic int lowest(input logic [7:0] h);
        for (int i = 0; i < 8; i++) if (h[i]) return i;
        return -1;
    endfunction

    function automatic void model_reset();
        for (int s = 0; s < 4; s++) begin
            lq[s].delete();
            for (int w = 0; w < 8; w++) begin
                lq[s].push_back(w);
                mb[s][w] = 1'b0;
                tn[s][w] = 1'b0;
            end
        end
    endfunction

    function automatic void model_update(input int a, input int h);
        int lo, hi, n, mid;
        bit all_set;
        for (int k = 0; k < lq[a].size(); k++) begin
            if (lq[a][k] == h) begin
                lq[a].delete(k);
                break;
            end
        end
        lq[a].push_back(h);
        mb[a][h] = 1'b1;
        all_set  = 1'b1;
        for (int w = 0; w < 8; w++) if (!mb[a][w]) all_set = 1'b0;
        if (all_set) begin
            for (int w = 0; w < 8; w++) mb[a][w] = 1'b0;
            mb[a][h] = 1'b1;
        end
        lo = 0; hi = 8; n = 1;
        while (hi - lo > 1) begin
            mid = (lo + hi) / 2;
            if (h < mid) begin
                tn[a][n] = 1'b1; hi = mid; n = 2 * n;
            end else begin
                tn[a][n] = 1'b0; lo = mid; n = 2 * n + 1;
            end
        end
    endfunction

    function automatic int model_victim(input int p, input int a);
        int lo, hi, n, mid;
        if (p == 1) begin
            for (int w = 0; w < 8; w++) if (!mb[a][w]) return w;
            return 0;
        end else if (p == 2) begin
            lo = 0; hi = 8; n = 1;
            while (hi - lo > 1) begin
                mid = (lo + hi) / 2;
                if (tn[a][n]) begin lo = mid; n = 2 * n + 1; end
                else begin hi = mid; n = 2 * n; end
            end
            return lo;
        end
        return lq[a][0];
    endfunction

    // ---------------- directed table ----------------
    typedef struct {
        bit       rst;
        int       dut;
        bit       we;
        logic [3:0] hit;
        int       exp;
    } vec_t;

    vec_t tbl [$];

    function automatic void add(input bit rst, input int dut, input bit we,
                                input logic [3:0] hit, input int exp);
        vec_t v;
        v.rst = rst; v.dut = dut; v.we = we; v.hit = hit; v.exp = exp;
        tbl.push_back(v);
    endfunction

    function automatic void add_misses(input int dut, input int seq [8]);
        for (int i = 0; i < 8; i++) begin
            add(i == 0, dut, 1'b1, 4'(1 << seq[i]), seq[i]);
        end
    endfunction

    initial begin
        int  seq_lru  [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
        // After way 3 fills only bit 3 is left; the next three fills (0,1,2) then
        // saturate again, leaving only bit 2, so the eighth victim is 0.
        int  seq_mru  [8] = '{0, 1, 2, 3, 0, 1, 2, 0};
        int  seq_tree [8] = '{0, 2, 1, 3, 0, 2, 1, 3};
        bit  rr;
        int  r;

        reset     = 1'b0;
        zero_addr = 1'b0;
        for (int p = 0; p < 3; p++) begin
            we_s[p]  = 1'b0;
            hit_s[p] = '0;
        end
        we_m = 1'b0; hit_m = '0; addr_m = 1'b0;
        we_b = 1'b0; hit_b = '0; addr_b = '0;

        for (int p = 0; p < 3; p++) add(1'b1, p, 1'b0, 4'b0000, 0);
        add_misses(0, seq_lru);
        add_misses(1, seq_mru);
        add(1'b0, 1, 1'b0, 4'b0000, 1);
        add_misses(2, seq_tree);
        // LRU recency, including an empty way_hit strobe
        add(1'b1, 0, 1'b1, 4'b0001, 0);
        add(1'b0, 0, 1'b1, 4'b0010, 1);
        add(1'b0, 0, 1'b1, 4'b0100, 2);
        add(1'b0, 0, 1'b1, 4'b0000, 3);
        add(1'b0, 0, 1'b0, 4'b0000, 3);
        // multi-bit way_hit: lowest bit (way 1) is the one used
        add(1'b1, 0, 1'b1, 4'b0110, 0);
        add(1'b0, 0, 1'b1, 4'b0001, 0);
        add(1'b0, 0, 1'b0, 4'b0000, 2);

        do_reset();
        foreach (tbl[i]) begin
            if (tbl[i].rst) do_reset();
            check($sformatf("vec%0d_pol%0d", i, tbl[i].dut), int'(sel_s[tbl[i].dut]), tbl[i].exp);
            if (tbl[i].we) begin
                we_s[tbl[i].dut]  = 1'b1;
                hit_s[tbl[i].dut] = tbl[i].hit;
                tick();
                we_s[tbl[i].dut]  = 1'b0;
                hit_s[tbl[i].dut] = '0;
            end
        end

        // ---- two-set LRU: isolation, reset priority, back-to-back ----
        do_reset();
        addr_m = 1'b1; we_m = 1'b1; hit_m = 4'b0001;
        tick();
        we_m = 1'b0; hit_m = '0;
        check("multi_set1_after_hit0", int'(sel_m), 1);
        addr_m = 1'b0; #1;
        check("multi_set0_untouched", int'(sel_m), 0);
        we_m = 1'b1; hit_m = 4'b0001;
        tick();
        we_m = 1'b0; hit_m = '0;
        check("multi_set0_after_hit0", int'(sel_m), 1);
        addr_m = 1'b1; #1;
        check("multi_set1_still", int'(sel_m), 1);
        reset = 1'b0; we_m = 1'b1; hit_m = 4'b0010;
        tick();
        reset = 1'b1; we_m = 1'b0; hit_m = '0;
        check("multi_reset_set1", int'(sel_m), 0);
        addr_m = 1'b0; #1;
        check("multi_reset_set0", int'(sel_m), 0);
        addr_m = 1'b1; we_m = 1'b1;
        for (int k = 0; k < 3; k++) begin
            hit_m = 4'(1 << k);
            tick();
            check($sformatf("multi_b2b_%0d", k), int'(sel_m), k + 1);
        end
        we_m = 1'b0; hit_m = '0;
        addr_m = 1'b0; #1;
        check("multi_b2b_set0", int'(sel_m), 0);

        // ---- random stimulus against the model ----
        do_reset();
        model_reset();
        for (int c = 0; c < 400; c++) begin
            addr_b = 2'($urandom_range(0, 3));
            r      = $urandom_range(0, 9);
            if (r < 6)      hit_b = 8'(1 << $urandom_range(0, 7));
            else if (r < 8) hit_b = 8'($urandom);
            else            hit_b = '0;
            we_b  = ($urandom_range(0, 3) != 0);
            rr    = ($urandom_range(0, 49) == 0);
            reset = ~rr;
            #1;
            for (int p = 0; p < 4; p++) begin
                check($sformatf("rand_c%0d_pol%0d_set%0d", c, p, addr_b),
                      int'(sel_b[p]), model_victim(p, int'(addr_b)));
            end
            @(posedge clk);
            if (rr) model_reset();
            else if (we_b && hit_b != 0) model_update(int'(addr_b), lowest(hit_b));
            #1;
        end
        reset = 1'b1; we_b = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
